console_tx: RTL and testbench

Memory-mapped console transmitter that sits on the core's data-memory bus as a responder, alongside the dual-port RAM. It accepts byte stores into a TX FIFO and serialises them as 8N1 UART frames on `tx_o`. The core keeps byte-storing to 0x000fffff, so the block gives the simulator console a synthesizable path to real hardware. The top-level decoder routes `dmem_valid` to this block for the 16-byte window at `BASE_ADDR` and muxes `rdata_o`/`ready_o` back.

---
 rtl/console_tx.sv | 336 +++++++++++++++++++++++++++++++++
 tb/tb_console_tx.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/console_tx.sv
// ---------------------------------------------------------------------------
// console_tx
//
// Memory-mapped console transmitter. It is a responder on the data-memory bus.
// Byte stores to the TXDATA register go into a TX FIFO. The FIFO drains as
// 8N1 UART frames on tx_o.
//
// Register window (offset from BASE_ADDR, decoded on offset bits [3:2]):
//   0x0 DIV    R/W  [15:0] clk cycles per bit (a write of 0 stores 1)
//   0x4 CTRL   R/W  [0] irq_en
//   0x8 STATUS RO   [0] full, [1] empty, [2] tx_busy, [11:8] count (saturating)
//   0xC TXDATA WO   lane 3 (wdata_i[31:24]) pushes a byte; reads return 0
//
// Ports:
//   clk      in   clock, rising edge
//   rst_n    in   asynchronous reset, active low
//   valid_i  in   request valid, held until ready_o
//   ready_o  out  one-cycle response strobe
//   addr_i   in   byte address
//   wdata_i  in   write data
//   we_i     in   byte write enables (0 = read)
//   rdata_o  out  read data, meaningful while ready_o is high
//   tx_o     out  UART serial line, idle high
//   irq_o    out  level interrupt: irq_en & FIFO empty & transmitter idle
// ---------------------------------------------------------------------------
module console_tx #(
    parameter logic [31:0] BASE_ADDR  = 32'h000f_fff0,
    parameter logic [15:0] CLK_DIV    = 16'd868,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  we_i,
    output logic [31:0] rdata_o,
    output logic        tx_o,
    output logic        irq_o
);

    localparam int IDX_W = $clog2(FIFO_DEPTH);
    localparam int PTR_W = IDX_W + 1;

    localparam logic [1:0] REG_DIV    = 2'd0;
    localparam logic [1:0] REG_CTRL   = 2'd1;
    localparam logic [1:0] REG_STATUS = 2'd2;
    localparam logic [1:0] REG_TXDATA = 2'd3;

    typedef enum logic [1:0] {
        BUS_IDLE,
        BUS_RESP,
        BUS_STALL
    } bus_state_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    // Bus side
    bus_state_t  bus_state;
    bus_state_t  bus_next;
    logic [31:0] offset;
    logic [1:0]  sel;
    logic [1:0]  req_sel;
    logic [31:0] req_wdata;
    logic [3:0]  req_we;
    logic [31:0] read_data;
    logic [31:0] rdata_q;
    logic        commit;
    logic        accept;

    // Configuration registers
    logic [15:0] div_reg;
    logic [15:0] div_written;
    logic        irq_en;

    // FIFO
    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] fifo_count;
    logic [7:0]       count_wide;
    logic [3:0]       count_disp;
    logic             fifo_empty;
    logic             fifo_full;
    logic [7:0]       fifo_head;
    logic             push;
    logic             pop;

    // Transmitter
    tx_state_t   tx_state;
    tx_state_t   tx_next;
    logic [15:0] frame_div;
    logic [15:0] div_next;
    logic [15:0] cyc_cnt;
    logic [15:0] cyc_next;
    logic [2:0]  bit_idx;
    logic [2:0]  bit_next;
    logic [7:0]  shift_reg;
    logic [7:0]  shift_next;
    logic        bit_end;
    logic        tx_busy;
    logic        line_q;
    logic        line_next;

    // Decoding is relative to BASE_ADDR, so a base that is word-aligned but not
    // 16-byte aligned still maps the four registers in order.
    assign offset = addr_i - BASE_ADDR;
    assign sel    = offset[2 +: 2];

    logic unused_bits;
    assign unused_bits = ^{offset[31:4], offset[1:0], req_wdata[23:16], req_we[2]};

    // FIFO status. The pointers carry one extra wrap bit: equal pointers mean
    // empty, and pointers that differ only in the wrap bit mean full.
    assign fifo_count = wr_ptr - rd_ptr;
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) &&
                        (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]);
    assign fifo_head  = fifo_mem[rd_ptr[IDX_W-1:0]];
    assign count_wide = 8'(fifo_count);
    assign count_disp = (count_wide > 8'd15) ? 4'hF : count_wide[3:0];

    assign tx_busy = (tx_state != TX_IDLE);
    assign bit_end = (cyc_cnt == frame_div - 16'd1);

    assign commit = (bus_state == BUS_RESP);
    assign accept = (bus_state == BUS_IDLE) && valid_i;
    assign push   = commit && (req_sel == REG_TXDATA) && req_we[3] && !fifo_full;

    assign ready_o = commit;
    assign rdata_o = rdata_q;
    assign tx_o    = line_q;
    assign irq_o   = irq_en & fifo_empty & ~tx_busy;

    // Bus next state. Only a lane-3 TXDATA store that finds the FIFO full
    // parks in STALL. Nothing else pushes, so once STALL sees space the
    // push in RESP is guaranteed to fit.
    always_comb begin
        bus_next = bus_state;
        case (bus_state)
            BUS_IDLE: begin
                if (valid_i) begin
                    if (sel == REG_TXDATA && we_i[3] && fifo_full) begin
                        bus_next = BUS_STALL;
                    end else begin
                        bus_next = BUS_RESP;
                    end
                end
            end
            BUS_STALL: begin
                if (!fifo_full) begin
                    bus_next = BUS_RESP;
                end
            end
            BUS_RESP: bus_next = BUS_IDLE;
            default:  bus_next = BUS_IDLE;
        endcase
    end

    // Bus state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_state <= BUS_IDLE;
        end else begin
            bus_state <= bus_next;
        end
    end

    // Capture the request when it is accepted. The initiator keeps driving it,
    // but the copy keeps the commit in RESP independent of the bus after that.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_sel   <= 2'd0;
            req_wdata <= 32'd0;
            req_we    <= 4'd0;
        end else if (accept) begin
            req_sel   <= sel;
            req_wdata <= wdata_i;
            req_we    <= we_i;
        end
    end

    // Read mux. It is sampled on the edge into RESP, so rdata_o shows the
    // register state from the cycle the request was accepted.
    always_comb begin
        read_data = 32'd0;
        case (sel)
            REG_DIV:    read_data = {16'd0, div_reg};
            REG_CTRL:   read_data = {31'd0, irq_en};
            REG_STATUS: read_data = {20'd0, count_disp, 5'd0, tx_busy, fifo_empty, fifo_full};
            default:    read_data = 32'd0;
        endcase
    end

    // Read data register. It holds its value between reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= 32'd0;
        end else if (accept && we_i == 4'b0000) begin
            rdata_q <= read_data;
        end
    end

    // DIV and CTRL writes commit at the end of RESP. Only lanes that cover
    // each field count. A divider of zero would never end a bit, so it is
    // stored as one.
    assign div_written = {req_we[1] ? req_wdata[15:8] : div_reg[15:8],
                          req_we[0] ? req_wdata[7:0]  : div_reg[7:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_reg <= CLK_DIV;
            irq_en  <= 1'b0;
        end else if (commit) begin
            if (req_sel == REG_DIV && (req_we[1] || req_we[0])) begin
                div_reg <= (div_written == 16'd0) ? 16'd1 : div_written;
            end
            if (req_sel == REG_CTRL && req_we[0]) begin
                irq_en <= req_wdata[0];
            end
        end
    end

    // FIFO storage. Data is not reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr[IDX_W-1:0]] <= req_wdata[31:24];
        end
    end

    // FIFO pointers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Transmitter next state. The head byte is popped on the edge into START,
    // and the divider is sampled on that edge too. A DIV write therefore never
    // changes a frame already on the line. STOP goes straight to START when
    // more data is waiting, so back-to-back frames have no idle gap. The line
    // value is computed for the next state and registered, which keeps tx_o
    // glitch-free.
    always_comb begin
        tx_next    = tx_state;
        pop        = 1'b0;
        cyc_next   = cyc_cnt + 16'd1;
        bit_next   = bit_idx;
        shift_next = shift_reg;
        div_next   = frame_div;
        line_next  = 1'b1;
        case (tx_state)
            TX_IDLE: begin
                cyc_next = 16'd0;
                if (!fifo_empty) begin
                    tx_next    = TX_START;
                    pop        = 1'b1;
                    shift_next = fifo_head;
                    div_next   = div_reg;
                end
            end
            TX_START: begin
                if (bit_end) begin
                    tx_next  = TX_DATA;
                    bit_next = 3'd0;
                    cyc_next = 16'd0;
                end
            end
            TX_DATA: begin
                if (bit_end) begin
                    cyc_next = 16'd0;
                    if (bit_idx == 3'd7) begin
                        tx_next = TX_STOP;
                    end else begin
                        bit_next   = bit_idx + 3'd1;
                        shift_next = shift_reg >> 1;
                    end
                end
            end
            TX_STOP: begin
                if (bit_end) begin
                    cyc_next = 16'd0;
                    if (!fifo_empty) begin
                        tx_next    = TX_START;
                        pop        = 1'b1;
                        shift_next = fifo_head;
                        div_next   = div_reg;
                    end else begin
                        tx_next = TX_IDLE;
                    end
                end
            end
            default: tx_next = TX_IDLE;
        endcase
        case (tx_next)
            TX_START: line_next = 1'b0;
            TX_DATA:  line_next = shift_next[0];
            default:  line_next = 1'b1;
        endcase
    end

    // Transmitter registers. Reset drops any frame in flight and returns the
    // line to idle high at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state  <= TX_IDLE;
            frame_div <= CLK_DIV;
            cyc_cnt   <= 16'd0;
            bit_idx   <= 3'd0;
            shift_reg <= 8'd0;
            line_q    <= 1'b1;
        end else begin
            tx_state  <= tx_next;
            frame_div <= div_next;
            cyc_cnt   <= cyc_next;
            bit_idx   <= bit_next;
            shift_reg <= shift_next;
            line_q    <= line_next;
        end
    end

endmodule

// File: tb/tb_console_tx.sv
// ---------------------------------------------------------------------------
// tb_console_tx
//
// Scoreboard bench for console_tx. The driver pushes the expected bus
// responses and the expected UART frames into queues. Two monitors decode
// ready_o/rdata_o and the tx_o line, then pop and compare.
// ---------------------------------------------------------------------------
module tb_console_tx;

    localparam logic [31:0] A_DIV    = 32'h000f_fff0;
    localparam logic [31:0] A_CTRL   = 32'h000f_fff4;
    localparam logic [31:0] A_STATUS = 32'h000f_fff8;
    localparam logic [31:0] A_TXDATA = 32'h000f_fffc;
    localparam logic [31:0] A_CONSOLE = 32'h000f_ffff;

    typedef struct {
        logic        chk;
        logic [31:0] rdata;
    } bus_exp_t;

    typedef struct {
        logic [7:0] data;
        logic       contig;
        logic       lat2;
    } frame_exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_i;
    logic        ready_o;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic [3:0]  we_i;
    logic [31:0] rdata_o;
    logic        tx_o;
    logic        irq_o;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int cur_div = 868;
    int last_rdy = 0;
    int push_rdy_cyc = 0;
    int last_end = -10;

    bus_exp_t   bus_q[$];
    frame_exp_t tx_q[$];

    console_tx dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .addr_i  (addr_i),
        .wdata_i (wdata_i),
        .we_i    (we_i),
        .rdata_o (rdata_o),
        .tx_o    (tx_o),
        .irq_o   (irq_o)
    );

    // Free-running clock and cycle counter
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got=0x%08h want=0x%08h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // One bus access, issued at a negedge. Returns ready latency in cycles.
    // Valid is dropped when ready is seen, and an immediate follow-up call
    // re-raises it, which gives the minimum two-cycle spacing.
    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [3:0] we, input logic [31:0] exp_rdata,
                                 output int lat);
        bus_exp_t e;
        int       start_c;
        bit       seen;
        e.chk   = (we == 4'b0000);
        e.rdata = exp_rdata;
        bus_q.push_back(e);
        addr_i  = addr;
        wdata_i = wdata;
        we_i    = we;
        valid_i = 1'b1;
        start_c = cyc;
        seen    = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            if (ready_o === 1'b1) seen = 1'b1;
        end
        valid_i = 1'b0;
        we_i    = 4'b0000;
        if (!seen) checkOutput("ready_timeout", 32'd0, 32'd1);
        lat      = cyc - start_c;
        last_rdy = cyc;
    endtask

    task automatic expectFrame(input logic [7:0] data, input logic contig, input logic lat2);
        frame_exp_t f;
        f.data   = data;
        f.contig = contig;
        f.lat2   = lat2;
        tx_q.push_back(f);
    endtask

    task automatic waitDrain(input int budget);
        int n;
        n = 0;
        while (tx_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput("tx_drain", tx_q.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    // Bus monitor: every ready_o pulse consumes one expected response
    initial begin : bus_monitor
        bus_exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && ready_o === 1'b1) begin
                if (bus_q.size() == 0) begin
                    checkOutput("ready_expected", 32'd0, 32'd1);
                end else begin
                    e = bus_q.pop_front();
                    if (e.chk) checkOutput("read_data", rdata_o, e.rdata);
                end
            end
        end
    end

    // UART monitor: decodes 8N1 frames at the current divider. Each bit must
    // hold steady for exactly cur_div cycles. A frame cut by reset is dropped.
    initial begin : uart_monitor
        int         d;
        int         start_c;
        logic [7:0] got;
        logic       stable;
        logic       aborted;
        logic       bv;
        frame_exp_t f;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && tx_o === 1'b0) begin
                d       = cur_div;
                start_c = cyc;
                got     = 8'd0;
                stable  = 1'b1;
                aborted = 1'b0;
                bv      = 1'b0;
                for (int b = 0; b < 10 && !aborted; b++) begin
                    for (int c = 0; c < d && !aborted; c++) begin
                        if (b != 0 || c != 0) @(negedge clk);
                        if (rst_n !== 1'b1) begin
                            aborted = 1'b1;
                        end else if (c == 0) begin
                            bv = tx_o;
                        end else if (tx_o !== bv) begin
                            stable = 1'b0;
                        end
                    end
                    if (!aborted) begin
                        if (b == 9 && bv !== 1'b1) stable = 1'b0;
                        if (b >= 1 && b <= 8) got[b-1] = bv;
                    end
                end
                if (!aborted) begin
                    if (tx_q.size() == 0) begin
                        checkOutput("frame_expected", 32'd0, 32'd1);
                    end else begin
                        f = tx_q.pop_front();
                        checkOutput("frame_data", {24'd0, got}, {24'd0, f.data});
                        checkOutput("frame_shape", {31'd0, stable}, 32'd1);
                        if (f.contig) checkOutput("frame_contig", start_c, last_end + 1);
                        if (f.lat2) checkOutput("frame_latency", start_c - push_rdy_cyc, 32'd2);
                    end
                    last_end = cyc;
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        int lat;
        int rdy[10];

        rst_n   = 1'b0;
        valid_i = 1'b0;
        addr_i  = 32'd0;
        wdata_i = 32'd0;
        we_i    = 4'd0;

        // Reset values
        repeat (3) @(negedge clk);
        checkOutput("reset_ready", {31'd0, ready_o}, 32'd0);
        checkOutput("reset_rdata", rdata_o, 32'd0);
        checkOutput("reset_tx", {31'd0, tx_o}, 32'd1);
        checkOutput("reset_irq", {31'd0, irq_o}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // STATUS and DIV after reset
        $display("[TB] reset values and first reads");
        applyStimulus(A_STATUS, 32'd0, 4'b0000, 32'h0000_0002, lat);
        checkOutput("read_latency", lat, 32'd1);
        checkOutput("idle_tx", {31'd0, tx_o}, 32'd1);
        @(negedge clk);
        applyStimulus(A_DIV, 32'd0, 4'b0000, 32'd868, lat);
        @(negedge clk);

        // Single frame, DIV=4, byte store of 'A' to the console address
        $display("[TB] single frame at div 4");
        applyStimulus(A_DIV, 32'd4, 4'b0011, 32'd0, lat);
        cur_div = 4;
        @(negedge clk);
        expectFrame(8'h41, 1'b0, 1'b1);
        applyStimulus(A_CONSOLE, 32'h4100_0000, 4'b1000, 32'd0, lat);
        push_rdy_cyc = last_rdy;
        waitDrain(200);

        // Ten back-to-back pushes at DIV=2. The first byte leaves the FIFO at
        // once, so the FIFO is full after the ninth push and the tenth stalls.
        $display("[TB] burst with stall at div 2");
        applyStimulus(A_DIV, 32'd2, 4'b0011, 32'd0, lat);
        cur_div = 2;
        @(negedge clk);
        for (int k = 0; k < 9; k++) begin
            expectFrame(8'(k), (k != 0), 1'b0);
            applyStimulus(A_CONSOLE, {8'(k), 24'd0}, 4'b1000, 32'd0, lat);
            rdy[k] = last_rdy;
        end
        applyStimulus(A_STATUS, 32'd0, 4'b0000, 32'h0000_0805, lat);
        expectFrame(8'h09, 1'b1, 1'b0);
        applyStimulus(A_CONSOLE, 32'h0900_0000, 4'b1000, 32'd0, lat);
        rdy[9] = last_rdy;
        for (int k = 1; k < 9; k++) checkOutput("push_spacing", rdy[k] - rdy[k-1], 32'd2);
        checkOutput("stall_release", rdy[9] - rdy[0], 32'd23);
        waitDrain(400);

        // Drain interrupt at DIV=1
        $display("[TB] drain interrupt");
        applyStimulus(A_DIV, 32'd1, 4'b0011, 32'd0, lat);
        cur_div = 1;
        @(negedge clk);
        applyStimulus(A_CTRL, 32'd1, 4'b0001, 32'd0, lat);
        @(negedge clk);
        checkOutput("irq_enabled_idle", {31'd0, irq_o}, 32'd1);
        expectFrame(8'h5A, 1'b0, 1'b1);
        applyStimulus(A_CONSOLE, 32'h5A00_0000, 4'b1000, 32'd0, lat);
        push_rdy_cyc = last_rdy;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            checkOutput("irq_frame", {31'd0, irq_o}, {31'd0, (c == 12)});
        end
        applyStimulus(A_CTRL, 32'd0, 4'b0001, 32'd0, lat);
        @(negedge clk);
        checkOutput("irq_disabled", {31'd0, irq_o}, 32'd0);
        waitDrain(50);

        // DIV=0 stores 1. A TXDATA write on lane 0 only is ignored.
        $display("[TB] divider zero and ignored lanes");
        applyStimulus(A_DIV, 32'd0, 4'b0011, 32'd0, lat);
        applyStimulus(A_DIV, 32'd0, 4'b0000, 32'd1, lat);
        applyStimulus(A_TXDATA, 32'h0000_00AA, 4'b0001, 32'd0, lat);
        applyStimulus(A_STATUS, 32'd0, 4'b0000, 32'h0000_0002, lat);
        repeat (30) @(negedge clk);

        // Reset in the middle of the data bits with three bytes queued
        $display("[TB] reset mid-frame");
        applyStimulus(A_DIV, 32'd4, 4'b0011, 32'd0, lat);
        cur_div = 4;
        @(negedge clk);
        applyStimulus(A_CONSOLE, 32'h1100_0000, 4'b1000, 32'd0, lat);
        applyStimulus(A_CONSOLE, 32'h2200_0000, 4'b1000, 32'd0, lat);
        applyStimulus(A_CONSOLE, 32'h3300_0000, 4'b1000, 32'd0, lat);
        repeat (8) @(negedge clk);
        checkOutput("tx_before_reset", {31'd0, tx_o}, 32'd0);
        rst_n = 1'b0;
        #1;
        checkOutput("reset_tx_async", {31'd0, tx_o}, 32'd1);
        checkOutput("reset_ready_async", {31'd0, ready_o}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        applyStimulus(A_STATUS, 32'd0, 4'b0000, 32'h0000_0002, lat);
        applyStimulus(A_DIV, 32'd0, 4'b0000, 32'd868, lat);
        repeat (100) @(negedge clk);

        checkOutput("bus_queue_empty", bus_q.size(), 32'd0);
        checkOutput("frame_queue_empty", tx_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
